valu_result_demux: RTL and testbench
====================================

// Module: valu_result_demux
// PURPOSE
//   Registered 1-to-LANES demultiplexer for 32-bit vALU results: the inverse of
//   the operand mux. Takes one word per cycle on a valid/ready input and routes it
//   by a select into one of LANES single-entry output buffers. Each buffer has its
//   own valid/ready handshake. Sits between the ALU result bus and its consumers.
// PARAMETERS
//   WIDTH  32  data word width
//   LANES  4   number of output lanes (destinations)
//   SEL_W  3   select width; codes >= LANES are invalid and dropped
//   CNT_W  8   width of accept_count and drop_count
// PORTS
//   clk          in   1            rising-edge clock
//   reset        in   1            synchronous, active-high reset
//   in_valid     in   1            in_data/in_sel valid this cycle
//   in_ready     out  1            block accepts the word this cycle
//   in_sel       in   SEL_W        destination lane index
//   in_data      in   WIDTH        result word
//   out_valid    out  LANES        lane i holds a word
//   out_ready    in   LANES        consumer i takes the word this cycle
//   out_data     out  LANES*WIDTH  lane i data at [i*WIDTH +: WIDTH]
//   accept_count out  CNT_W        words accepted into lanes, wraps mod 2^CNT_W
//   drop_count   out  CNT_W        words with invalid in_sel, saturates at max
// BEHAVIOUR
//   Reset (sync, active-high): all out_valid=0, all out_data=0, accept_count=0,
//     drop_count=0. Reset wins over any same-cycle transfer; buffered words are lost.
//   in_ready (combinational, independent of in_valid):
//     in_sel <  LANES: !out_valid[in_sel] || out_ready[in_sel]
//     in_sel >= LANES: 1 (word is always drained and dropped)
//   Accept = in_valid && in_ready && in_sel < LANES: at the next edge lane in_sel
//     loads in_data, out_valid[in_sel]=1, accept_count += 1 (wraps).
//   Drop = in_valid && in_sel >= LANES: no lane changes; drop_count += 1, holds at
//     2^CNT_W-1.
//   Drain: out_valid[i] && out_ready[i] clears out_valid[i] at the next edge,
//     unless the same lane is loaded that cycle. Then out_valid[i] stays 1 and
//     out_data[i] takes the new word (full throughput, no bubble).
//   Latency: accepted word is visible on out_valid/out_data 1 cycle after accept.
//   Stall: when out_valid[i]=1 and out_ready[i]=0, out_data[i] holds stable. out_ready
//     with out_valid=0 has no effect.
//   out_data[i] keeps its last value after drain; consumers qualify it with out_valid.
//   Lanes are independent: a stall on one lane never blocks words routed to other lanes.
//   At most one lane is loaded per cycle; any number of lanes may drain together.
//   in_data/in_sel are don't-care when in_valid=0; no state or counter changes.
// TESTING
//   1 reset; in_sel=0,in_data=32'h1,in_valid 1 cyc, out_ready=0 -> next cyc
//     out_valid=4'b0001, out_data[31:0]=1, held for 5 cyc; accept_count=1
//   2 lane1 full, out_ready[1]=0; in_sel=1 -> in_ready=0, no change; then in_sel=2,
//     data=32'h4 -> in_ready=1, out_valid=4'b0110
//   3 lane0 full(1), out_ready[0]=1, in_sel=0,data=32'h2 same cyc -> in_ready=1,
//     out_valid[0] stays 1, out_data[31:0]=2, accept_count +1
//   4 in_sel=5,in_valid=1 -> in_ready=1, out_valid unchanged, drop_count=1; 300
//     consecutive drops -> drop_count=255
//   5 all 4 lanes full, assert reset 1 cyc mid-stall -> out_valid=0, out_data=0,
//     both counts 0
//   6 stream 2**k, sel=k%4, out_ready=4'hF, 256 words -> every word appears on its
//     lane 1 cyc later in order, no stalls, accept_count wraps to 0

Source files
------------

// File: rtl/valu_result_demux.sv
// rtl/valu_result_demux.sv - registered 1-to-LANES demultiplexer for vALU result words
module valu_result_demux #(
  parameter int WIDTH = 32,
  parameter int LANES = 4,
  parameter int SEL_W = 3,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic [WIDTH-1:0]         in_data,
  output logic [LANES-1:0]         out_valid,
  input  logic [LANES-1:0]         out_ready,
  output logic [LANES*WIDTH-1:0]   out_data,
  output logic [CNT_W-1:0]         accept_count,
  output logic [CNT_W-1:0]         drop_count
);

  // Select widened to 32 bits so the range test works for any SEL_W/LANES mix
  logic [31:0]      sel_ext;
  logic             sel_ok;
  logic [LANES-1:0] lane_hit;
  logic [LANES-1:0] lane_free;
  logic [LANES-1:0] lane_load;
  logic             accept;
  logic             drop;

  assign sel_ext = 32'(in_sel);
  assign sel_ok  = (sel_ext < 32'(LANES));

  // Per-lane decode of the select and of whether the lane can take a word now
  always_comb begin
    lane_hit  = '0;
    lane_free = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_hit[i]  = (sel_ext == 32'(i));
      lane_free[i] = !out_valid[i] || out_ready[i];
    end
  end

  // Invalid selects are always drained; valid ones wait for their own lane only
  always_comb begin
    in_ready = !sel_ok || (|(lane_hit & lane_free));
  end

  // Transfer classification and one-hot lane load strobe
  always_comb begin
    accept    = in_valid && in_ready && sel_ok;
    drop      = in_valid && !sel_ok;
    lane_load = accept ? lane_hit : '0;
  end

  // Lane occupancy: a load wins over a same-cycle drain so the lane never bubbles
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_load[i]) begin
          out_valid[i] <= 1'b1;
        end else if (out_ready[i]) begin
          out_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Lane data: only written on load, so it holds through stalls and after drain
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_load[i]) begin
          out_data[i*WIDTH +: WIDTH] <= in_data;
        end
      end
    end
  end

  // Accepted words counter, free-running modulo 2^CNT_W
  always_ff @(posedge clk) begin
    if (reset) begin
      accept_count <= '0;
    end else if (accept) begin
      accept_count <= accept_count + CNT_W'(1);
    end
  end

  // Dropped words counter, sticks at all-ones
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count <= '0;
    end else if (drop && (drop_count != {CNT_W{1'b1}})) begin
      drop_count <= drop_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_valu_result_demux.sv
// tb/tb_valu_result_demux.sv - table-driven bench for valu_result_demux
module tb_valu_result_demux;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_sel;
  logic [31:0]  in_data;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [127:0] out_data;
  logic [7:0]   accept_count;
  logic [7:0]   drop_count;

  int checks = 0;
  int errors = 0;

  valu_result_demux #(.WIDTH(32), .LANES(4), .SEL_W(3), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .accept_count(accept_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         v;
    logic [2:0]   sel;
    logic [31:0]  d;
    logic [3:0]   rdy;
    logic         exp_rdy;
    logic [3:0]   exp_ov;
    logic [127:0] exp_od;
    logic [7:0]   exp_acc;
    logic [7:0]   exp_drop;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t row(input logic rst, input logic v, input logic [2:0] sel,
                               input logic [31:0] d, input logic [3:0] rdy, input logic er,
                               input logic [3:0] eov, input logic [31:0] d0, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] d3,
                               input logic [7:0] acc, input logic [7:0] drp);
    vec_t r;
    r.rst = rst; r.v = v; r.sel = sel; r.d = d; r.rdy = rdy;
    r.exp_rdy = er; r.exp_ov = eov; r.exp_od = {d3, d2, d1, d0};
    r.exp_acc = acc; r.exp_drop = drp;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic v, input logic [2:0] sel,
                       input logic [31:0] d, input logic [3:0] rdy);
    @(negedge clk);
    reset = rst; in_valid = v; in_sel = sel; in_data = d; out_ready = rdy;
    #1;
  endtask

  task automatic settle_after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sel = 3'd5; in_data = '0; out_ready = '0;

    //                 rst  v   sel   data        rdy      er   eov      lane0 lane1 lane2 lane3 acc drop
    vecs.push_back(row(1'b1, 1'b0, 3'd5, 32'h0,  4'b0000, 1'b1, 4'b0000, 0, 0, 0, 0, 8'd0, 8'd0));
    vecs.push_back(row(1'b0, 1'b1, 3'd0, 32'h1,  4'b0000, 1'b1, 4'b0001, 1, 0, 0, 0, 8'd1, 8'd0));
    for (int k = 0; k < 5; k++)
      vecs.push_back(row(1'b0, 1'b0, 3'd0, 32'h0, 4'b0000, 1'b0, 4'b0001, 1, 0, 0, 0, 8'd1, 8'd0));
    vecs.push_back(row(1'b0, 1'b0, 3'd0, 32'h0,  4'b0001, 1'b1, 4'b0000, 1, 0, 0, 0, 8'd1, 8'd0));
    vecs.push_back(row(1'b0, 1'b1, 3'd1, 32'h3,  4'b0000, 1'b1, 4'b0010, 1, 3, 0, 0, 8'd2, 8'd0));
    vecs.push_back(row(1'b0, 1'b1, 3'd1, 32'h9,  4'b0000, 1'b0, 4'b0010, 1, 3, 0, 0, 8'd2, 8'd0));
    vecs.push_back(row(1'b0, 1'b1, 3'd2, 32'h4,  4'b0000, 1'b1, 4'b0110, 1, 3, 4, 0, 8'd3, 8'd0));
    vecs.push_back(row(1'b0, 1'b1, 3'd0, 32'h1,  4'b0000, 1'b1, 4'b0111, 1, 3, 4, 0, 8'd4, 8'd0));
    vecs.push_back(row(1'b0, 1'b1, 3'd0, 32'h2,  4'b0001, 1'b1, 4'b0111, 2, 3, 4, 0, 8'd5, 8'd0));
    vecs.push_back(row(1'b0, 1'b0, 3'd3, 32'h0,  4'b1000, 1'b1, 4'b0111, 2, 3, 4, 0, 8'd5, 8'd0));
    vecs.push_back(row(1'b0, 1'b1, 3'd5, 32'hdead, 4'b0000, 1'b1, 4'b0111, 2, 3, 4, 0, 8'd5, 8'd1));
    vecs.push_back(row(1'b0, 1'b1, 3'd4, 32'hbeef, 4'b0000, 1'b1, 4'b0111, 2, 3, 4, 0, 8'd5, 8'd2));
    vecs.push_back(row(1'b0, 1'b1, 3'd7, 32'hf00d, 4'b0000, 1'b1, 4'b0111, 2, 3, 4, 0, 8'd5, 8'd3));
    vecs.push_back(row(1'b0, 1'b0, 3'd6, 32'h0,  4'b0000, 1'b1, 4'b0111, 2, 3, 4, 0, 8'd5, 8'd3));
    vecs.push_back(row(1'b0, 1'b0, 3'd1, 32'h7,  4'b0000, 1'b0, 4'b0111, 2, 3, 4, 0, 8'd5, 8'd3));
    vecs.push_back(row(1'b0, 1'b1, 3'd3, 32'h8,  4'b0000, 1'b1, 4'b1111, 2, 3, 4, 8, 8'd6, 8'd3));
    vecs.push_back(row(1'b0, 1'b1, 3'd2, 32'h5,  4'b0000, 1'b0, 4'b1111, 2, 3, 4, 8, 8'd6, 8'd3));
    // reset mid-stall with every lane full and a word offered
    vecs.push_back(row(1'b1, 1'b1, 3'd0, 32'h6,  4'b0000, 1'b0, 4'b0000, 0, 0, 0, 0, 8'd0, 8'd0));

    for (int n = 0; n < vecs.size(); n++) begin
      drive(vecs[n].rst, vecs[n].v, vecs[n].sel, vecs[n].d, vecs[n].rdy);
      chk($sformatf("v%0d in_ready", n), 128'(in_ready), 128'(vecs[n].exp_rdy));
      settle_after_edge();
      chk($sformatf("v%0d out_valid", n), 128'(out_valid), 128'(vecs[n].exp_ov));
      chk($sformatf("v%0d out_data", n), out_data, vecs[n].exp_od);
      chk($sformatf("v%0d accept_count", n), 128'(accept_count), 128'(vecs[n].exp_acc));
      chk($sformatf("v%0d drop_count", n), 128'(drop_count), 128'(vecs[n].exp_drop));
    end

    // 300 back-to-back drops: counter saturates at 255
    for (int k = 0; k < 300; k++) begin
      drive(1'b0, 1'b1, 3'd5, 32'(k), 4'b0000);
      if (in_ready !== 1'b1) chk($sformatf("drop%0d in_ready", k), 128'(in_ready), 128'(1));
      settle_after_edge();
      if (k == 254) chk("drop255 drop_count", 128'(drop_count), 128'(255));
    end
    chk("sat drop_count", 128'(drop_count), 128'(255));
    chk("sat out_valid", 128'(out_valid), 128'(0));
    chk("sat accept_count", 128'(accept_count), 128'(0));

    // 256-word stream with all consumers ready: one-cycle latency, no stalls, count wraps
    begin
      logic [31:0] w;
      logic [1:0]  s;
      logic [3:0]  one_hot;
      int bad_rdy = 0, bad_ov = 0, bad_od = 0;
      for (int k = 0; k < 256; k++) begin
        w = 32'h1 << (k % 32);
        s = 2'(k % 4);
        one_hot = 4'b0001 << s;
        drive(1'b0, 1'b1, {1'b0, s}, w, 4'hf);
        if (in_ready !== 1'b1 && bad_rdy == 0) begin
          bad_rdy++;
          chk($sformatf("stream%0d in_ready", k), 128'(in_ready), 128'(1));
        end
        settle_after_edge();
        if (out_valid !== one_hot && bad_ov == 0) begin
          bad_ov++;
          chk($sformatf("stream%0d out_valid", k), 128'(out_valid), 128'(one_hot));
        end
        if (out_data[s*32 +: 32] !== w && bad_od == 0) begin
          bad_od++;
          chk($sformatf("stream%0d lane data", k), 128'(out_data[s*32 +: 32]), 128'(w));
        end
      end
      chk("stream last out_valid", 128'(out_valid), 128'(4'b1000));
      chk("stream last lane3", 128'(out_data[127:96]), 128'(32'h8000_0000));
      chk("stream accept_count wrap", 128'(accept_count), 128'(0));
      chk("stream drop_count", 128'(drop_count), 128'(255));
    end

    // idle cycle with ready high drains the final word
    drive(1'b0, 1'b0, 3'd3, 32'h0, 4'hf);
    settle_after_edge();
    chk("final drain out_valid", 128'(out_valid), 128'(0));
    chk("final lane3 retained", 128'(out_data[127:96]), 128'(32'h8000_0000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
